// File: rtl/uart_byte_receiver.sv
// Purpose : 8N1 UART receiver (16x oversampling) feeding a first-word-fall-through byte FIFO.
// Latency : a byte appears at rd_data one clk after its stop-bit sample; rd_data has no read latency.
// Backpr. : none on the serial side; a byte arriving while the FIFO is full (and not popped) is dropped and flagged by overrun.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset (release synchronized internally)
//   rx                 asynchronous serial input, idle high, LSB first
//   rd_en              pop request for the FIFO head (ignored when empty)
//   clr_err            clears frame_err / overrun (a same-cycle set wins)
//   rd_data            FIFO head byte, valid while empty=0
//   empty, full, count FIFO occupancy
//   rx_busy            receive FSM is not IDLE
//   frame_err, overrun sticky error flags
module uart_byte_receiver #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  input  logic                   rd_en,
  input  logic                   clr_err,
  output logic [7:0]             rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   rx_busy,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------------------
  // Reset: assert asynchronously, release on a clk edge so no flop sees the
  // release edge of rst_n itself.
  // ---------------------------------------------------------------------------
  logic [1:0] r_rst_pipe;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_pipe <= 2'b00;
    else        r_rst_pipe <= {r_rst_pipe[0], 1'b1};
  end

  assign w_rst_n = r_rst_pipe[1];

  // ---------------------------------------------------------------------------
  // rx synchronizer. r_sync_vld marks when r_rx_sync holds a real line sample
  // rather than its reset value; r_armed then blocks start detection until the
  // line has been seen high, so a frame cut by reset is never picked up midway.
  // ---------------------------------------------------------------------------
  logic       r_rx_meta;
  logic       r_rx_sync;
  logic [1:0] r_sync_vld;
  logic       r_armed;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_sync_vld <= 2'b00;
      r_armed    <= 1'b0;
    end else begin
      r_rx_meta  <= rx;
      r_rx_sync  <= r_rx_meta;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      if (r_sync_vld[1] && r_rx_sync) r_armed <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_tick_cnt;
  logic [3:0]    r_os_cnt;     // ticks seen in the current bit
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          w_tick;
  logic          w_start_entry;
  logic          w_os_clr;
  logic          w_sample;
  logic          w_byte_ok;
  logic          w_ferr_set;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start_entry = 1'b0;
    w_os_clr      = 1'b0;
    w_sample      = 1'b0;
    w_byte_ok     = 1'b0;
    w_ferr_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_armed && !r_rx_sync) begin
          w_state_nxt   = START;
          w_start_entry = 1'b1;
        end
      end
      START: begin
        // Mid-point of the start bit: still low means a real frame.
        if (w_tick && (r_os_cnt == 4'd7)) begin
          w_os_clr    = 1'b1;
          w_state_nxt = r_rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_tick && (r_os_cnt == 4'd15)) begin
          w_sample = 1'b1;
          if (r_bit_idx == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_tick && (r_os_cnt == 4'd15)) begin
          if (r_rx_sync) begin
            w_byte_ok   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (r_rx_sync) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Tick generator and bit-timing counters. The oversample counter wraps
  // 15 -> 0 by itself in DATA/STOP, so only START entry and the start-bit
  // decision need an explicit clear.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tick_cnt <= '0;
      r_os_cnt   <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      if (w_start_entry || w_tick) r_tick_cnt <= '0;
      else                         r_tick_cnt <= r_tick_cnt + 1'b1;

      if (w_start_entry || w_os_clr) r_os_cnt <= 4'd0;
      else if (w_tick)               r_os_cnt <= r_os_cnt + 4'd1;

      if (w_start_entry)  r_bit_idx <= 3'd0;
      else if (w_sample)  r_bit_idx <= r_bit_idx + 3'd1;

      if (w_sample) r_shift[r_bit_idx] <= r_rx_sync;
    end
  end

  assign rx_busy = (r_state != IDLE);

  // ---------------------------------------------------------------------------
  // FIFO. The push happens one clk after the stop sample; r_shift is stable
  // until the next frame's first data sample, so it is written directly.
  // ---------------------------------------------------------------------------
  logic          r_push_pend;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_ovr_set;

  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = rd_en && (r_count != '0);
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign w_wr_en   = r_push_pend && (!w_full || w_pop);
  assign w_ovr_set = r_push_pend && w_full && !w_pop;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_push_pend <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      r_push_pend <= w_byte_ok;
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign empty   = (r_count == '0);
  assign full    = w_full;

  // Sticky error flags: a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (w_ferr_set)   frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (w_ovr_set)    overrun   <= 1'b1;
      else if (clr_err) overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Purpose : self-checking bench for uart_byte_receiver (fast baud: 4 clk per tick, 64 clk per bit).
// Latency : expected push/flag edges are derived from the frame start edge.
// Backpr. : rd_en is driven by the bench; a queue model predicts occupancy, head byte and flags every cycle.
module tb_uart_byte_receiver;

  localparam int CLK_FREQ = 640000;
  localparam int BAUD     = 10000;
  localparam int DEPTH    = 4;
  localparam int D        = CLK_FREQ / (BAUD * 16);
  localparam int BIT      = 16 * D;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  uart_byte_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: byte queue plus sticky flags. The line falls just after
  // edge P; the line is synchronized in 2 clk, START is entered 1 clk later,
  // the stop bit is sampled on tick 8+16*9 = 152 after that, and the byte is
  // queued one clk later: stop sample at P+3+152*D, push at P+4+152*D.
  // ---------------------------------------------------------------------------
  logic [7:0] q[$];
  logic       m_ferr = 1'b0;
  logic       m_ovr  = 1'b0;
  int         push_at = -1;
  int         ferr_at = -1;
  logic [7:0] push_byte = 8'h00;
  int         last_start = 0;
  logic       mon_en = 1'b0;
  bit         m_pop, m_full, m_push, m_fset, m_oset;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      push_at = -1;
      ferr_at = -1;
    end else begin
      m_pop  = rd_en && (q.size() > 0);
      m_full = (q.size() == DEPTH);
      m_push = (cyc == push_at);
      m_fset = (cyc == ferr_at);
      m_oset = m_push && m_full && !m_pop;
      if (m_pop) void'(q.pop_front());
      if (m_push && !m_oset) q.push_back(push_byte);
      m_ferr = m_fset ? 1'b1 : (clr_err ? 1'b0 : m_ferr);
      m_ovr  = m_oset ? 1'b1 : (clr_err ? 1'b0 : m_ovr);
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_en && rst_n)
      check("model_track",
            {17'd0, count, empty, full, frame_err, overrun, (empty ? 8'h00 : rd_data)},
            {17'd0, 3'(q.size()), q.size() == 0, q.size() == DEPTH, m_ferr, m_ovr,
             (q.size() == 0 ? 8'h00 : q[0])});
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    @(posedge clk);
    #1;
    rx = 1'b0;
    last_start = cyc;
    if (stop_v) begin
      push_byte = b;
      push_at   = cyc + 4 + 152 * D;
    end else begin
      ferr_at   = cyc + 3 + 152 * D;
    end
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (BIT) @(posedge clk);
    #1 rx = stop_v;
    repeat (BIT) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  // Returns on the falling clk edge that follows rising edge number c.
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic pulse_rd();
    @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    @(negedge clk);
    check(name, rd_data, exp);
    pulse_rd();
  endtask

  typedef struct {
    logic [7:0] dat;
    logic       stop_b;
    logic       exp_empty;
    logic [7:0] exp_rd;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int thr;
    int n;
    logic [7:0] b;
    logic       sv;

    tbl[0] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0};
    tbl[2] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0};
    tbl[3] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b0};
    tbl[4] = '{8'h55, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[5] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b0};

    rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_rx_busy", rx_busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(posedge clk);

    // Single byte 0xA5, exact arrival edge.
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        #2;
        wait_cyc(push_at - 1);
        check("a5_empty_before_push", empty, 1'b1);
        wait_cyc(push_at);
        check("a5_empty", empty, 1'b0);
        check("a5_rd_data", rd_data, 8'hA5);
        check("a5_count", count, 3'd1);
      end
    join
    pop_check("a5_pop", 8'hA5);
    @(negedge clk);
    check("a5_empty_after_pop", empty, 1'b1);
    check("a5_count_after_pop", count, 3'd0);

    // Start-bit glitch of 4 ticks is rejected.
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (2 * D) @(posedge clk);
    @(negedge clk);
    check("glitch_busy", rx_busy, 1'b1);
    @(posedge clk);
    #1;
    repeat (2 * D - 1) @(posedge clk);
    #1 rx = 1'b1;
    repeat (12 * D) @(posedge clk);
    @(negedge clk);
    check("glitch_idle", rx_busy, 1'b0);
    check("glitch_empty", empty, 1'b1);
    check("glitch_ferr", frame_err, 1'b0);

    // Five bytes, no reads: fifth is dropped.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    @(negedge clk);
    check("ovf_full", full, 1'b1);
    check("ovf_count", count, 3'd4);
    check("ovf_overrun", overrun, 1'b1);
    pop_check("ovf_rd1", 8'h01);
    pop_check("ovf_rd2", 8'h02);
    pop_check("ovf_rd3", 8'h03);
    pop_check("ovf_rd4", 8'h04);
    @(negedge clk);
    check("ovf_drained", empty, 1'b1);
    pulse_clr();
    @(negedge clk);
    check("ovf_clr", overrun, 1'b0);

    // Full FIFO, pop on the exact push edge of 0x77.
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
    fork
      send_frame(8'h77, 1'b1);
      begin
        @(posedge clk);
        #2;
        wait_cyc(push_at - 1);
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(negedge clk);
        check("pp_count", count, 3'd4);
        check("pp_overrun", overrun, 1'b0);
        check("pp_full", full, 1'b1);
      end
    join
    pop_check("pp_rd1", 8'h12);
    pop_check("pp_rd2", 8'h13);
    pop_check("pp_rd3", 8'h14);
    pop_check("pp_rd4", 8'h77);

    // Stop bit forced low: frame error, no byte, busy until the line idles.
    fork
      send_frame(8'h3C, 1'b0);
      begin
        @(posedge clk);
        #2;
        wait_cyc(ferr_at);
        check("fe_flag", frame_err, 1'b1);
        wait_cyc(last_start + 160 * D - 1);
        check("fe_busy_line_low", rx_busy, 1'b1);
        check("fe_empty", empty, 1'b1);
      end
    join
    n = 0;
    while (rx_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("fe_busy_released", rx_busy, 1'b0);

    // Reset during bit 3 with a byte queued and frame_err set.
    send_frame(8'h99, 1'b1);
    fork
      send_frame(8'h00, 1'b1);
      begin
        @(posedge clk);
        #2;
        wait_cyc(last_start + 72 * D);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_empty", empty, 1'b1);
        check("mrst_full", full, 1'b0);
        check("mrst_count", count, 3'd0);
        check("mrst_rd_data", rd_data, 8'h00);
        check("mrst_ferr", frame_err, 1'b0);
        check("mrst_overrun", overrun, 1'b0);
        check("mrst_busy", rx_busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    repeat (16 * D) @(posedge clk);
    @(negedge clk);
    check("mrst_no_partial", empty, 1'b1);
    check("mrst_idle", rx_busy, 1'b0);
    send_frame(8'h5A, 1'b1);
    @(negedge clk);
    check("mrst_next_count", count, 3'd1);
    pop_check("mrst_next_byte", 8'h5A);

    // Table of single frames.
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].dat, tbl[i].stop_b);
      @(negedge clk);
      check($sformatf("tbl%0d_empty", i), empty, tbl[i].exp_empty);
      if (!tbl[i].exp_empty) check($sformatf("tbl%0d_rd", i), rd_data, tbl[i].exp_rd);
      check($sformatf("tbl%0d_ferr", i), frame_err, tbl[i].exp_ferr);
      pulse_rd();
      pulse_clr();
      repeat (4) @(posedge clk);
    end

    // Random frames with random reads and error clears.
    for (int f = 0; f < 14; f++) begin
      b   = 8'($urandom);
      sv  = ($urandom_range(0, 7) != 0);
      thr = $urandom_range(0, 3);
      thr = (thr == 3) ? 4 : thr;
      fork
        send_frame(b, sv);
        begin
          for (int c = 0; c < 160 * D; c++) begin
            @(posedge clk);
            #1;
            rd_en   = ($urandom_range(0, 511) < thr);
            clr_err = ($urandom_range(0, 1023) == 0);
          end
          rd_en   = 1'b0;
          clr_err = 1'b0;
        end
      join
      repeat ($urandom_range(2, 20)) @(posedge clk);
    end

    repeat (10) @(posedge clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
